// File: rtl/first_cnn_pkg.sv
// Shared types and sizing for the first CNN stage (conv -> maxpool -> flatten).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package first_cnn_pkg;

    localparam int CONV_W = 32;
    localparam int CONV_H = 32;
    localparam int POOL_W = CONV_W / 2;
    localparam int DATA_W = 8;

    typedef logic signed [DATA_W-1:0] pix_t;

    // Signed maximum; ties return b, which is value-identical to a.
    function automatic pix_t smax(pix_t a, pix_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/first_cnn_maxpool_if.sv
// Pixel stream bundle between the conv stage, the pooling stage and its consumer.
// Latency: n/a (wiring only).
// Backpressure: none; the stream is strobe-qualified and cannot be stalled.
//   slave : Frame_Start, Din_Valid, Din in; Dout_Valid, Dout, Frame_Done out (pooling block)
//   master: mirror of slave (conv stage / test driver side)
interface first_cnn_maxpool_if #(
    parameter int DW = 8
);
    logic                 Frame_Start;
    logic                 Din_Valid;
    logic signed [DW-1:0] Din;
    logic                 Dout_Valid;
    logic signed [DW-1:0] Dout;
    logic                 Frame_Done;

    modport master (
        output Frame_Start, Din_Valid, Din,
        input  Dout_Valid, Dout, Frame_Done
    );

    modport slave (
        input  Frame_Start, Din_Valid, Din,
        output Dout_Valid, Dout, Frame_Done
    );
endinterface

// File: rtl/first_cnn_pool_linebuf.sv
// One-row buffer of horizontal pair maxima (IMG_W/2 entries), written on even rows, read on odd rows.
// Latency: write lands at the next rising edge; read is combinational.
// Backpressure: none; storage is never reset since every entry is written before it is read.
//   clk, wr_en, wr_addr, wr_dat : single write port
//   rd_addr, rd_dat             : single combinational read port
module first_cnn_pool_linebuf #(
    parameter int DEPTH = 16,
    parameter int DW    = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic signed [DW-1:0] wr_dat,
    input  logic [AW-1:0]        rd_addr,
    output logic signed [DW-1:0] rd_dat
);

    logic signed [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/first_cnn_maxpool.sv
// Optional ReLU then 2x2 stride-2 max pooling of a raster conv map (IMG_W x IMG_H -> IMG_W/2 x IMG_H/2).
// Latency: Dout/Dout_Valid registered 1 cycle after the accepted (odd row, odd col) pixel.
// Backpressure: none; Din_Valid gaps freeze all state, output is a strobe the consumer must take.
//   clk, rst : single rising-edge clock, synchronous active-high reset
//   bus      : slave side of first_cnn_maxpool_if (Frame_Start/Din_Valid/Din in, Dout_Valid/Dout/Frame_Done out)
// DW must equal DATA_W because the compare helper works on pix_t.
module first_cnn_maxpool
    import first_cnn_pkg::*;
#(
    parameter int IMG_W   = CONV_W,
    parameter int IMG_H   = CONV_H,
    parameter int DW      = DATA_W,
    parameter int RELU_EN = 1
) (
    input logic               clk,
    input logic               rst,
    first_cnn_maxpool_if.slave bus
);

    localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LB_DEPTH = IMG_W / 2;
    localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    logic [CW-1:0]        col_q, col_d, col_cur;
    logic [RW-1:0]        row_q, row_d, row_cur;
    logic signed [DW-1:0] h_reg_q, h_reg_d;
    logic signed [DW-1:0] dout_q, dout_d;
    logic                 dout_vld_q, dout_vld_d;
    logic                 frame_done_q, frame_done_d;

    logic signed [DW-1:0] x;
    logic                 lb_wr_en;
    logic [AW-1:0]        lb_addr;
    logic signed [DW-1:0] lb_wr_dat;
    logic signed [DW-1:0] lb_rd_dat;

    first_cnn_pool_linebuf #(
        .DEPTH (LB_DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_linebuf (
        .clk     (clk),
        .wr_en   (lb_wr_en),
        .wr_addr (lb_addr),
        .wr_dat  (lb_wr_dat),
        .rd_addr (lb_addr),
        .rd_dat  (lb_rd_dat)
    );

    always_comb begin
        // Frame_Start overrides the position for this cycle, so a pixel
        // arriving with it is treated as (0,0).
        col_cur = bus.Frame_Start ? '0 : col_q;
        row_cur = bus.Frame_Start ? '0 : row_q;

        // Sign bit test keeps the clamp a pure DW-bit signed decision.
        x = ((RELU_EN != 0) && bus.Din[DW-1]) ? '0 : bus.Din;

        lb_addr   = AW'(col_cur >> 1);
        lb_wr_dat = smax(h_reg_q, x);
        lb_wr_en  = 1'b0;

        col_d        = col_cur;
        row_d        = row_cur;
        h_reg_d      = h_reg_q;
        dout_d       = '0;
        dout_vld_d   = 1'b0;
        frame_done_d = 1'b0;

        if (bus.Din_Valid) begin
            if (col_cur == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_cur == RW'(IMG_H - 1)) ? '0 : row_cur + 1'b1;
            end else begin
                col_d = col_cur + 1'b1;
            end

            case ({row_cur[0], col_cur[0]})
                // even row: reduce each horizontal pair and park it in the line buffer
                2'b00: h_reg_d  = x;
                2'b01: lb_wr_en = 1'b1;
                // odd row: fold the parked pair max with the two new pixels
                2'b10: h_reg_d  = smax(lb_rd_dat, x);
                default: begin
                    dout_d       = smax(h_reg_q, x);
                    dout_vld_d   = 1'b1;
                    frame_done_d = (row_cur == RW'(IMG_H - 1)) &&
                                   (col_cur == CW'(IMG_W - 1));
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            h_reg_q      <= '0;
            dout_q       <= '0;
            dout_vld_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            h_reg_q      <= h_reg_d;
            dout_q       <= dout_d;
            dout_vld_q   <= dout_vld_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.Dout       = dout_q;
    assign bus.Dout_Valid = dout_vld_q;
    assign bus.Frame_Done = frame_done_q;

endmodule

// File: tb/tb_first_cnn_maxpool.sv
// Scoreboard bench: two DUTs (RELU_EN=1 and RELU_EN=0) share one input stream;
// a frame-array reference model pushes expected pooled values, a negedge monitor pops and compares.
module tb_first_cnn_maxpool;
    import first_cnn_pkg::*;

    localparam int W = CONV_W;
    localparam int H = CONV_H;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    first_cnn_maxpool_if #(.DW(DATA_W)) ifc1 ();
    first_cnn_maxpool_if #(.DW(DATA_W)) ifc0 ();

    assign ifc0.Frame_Start = ifc1.Frame_Start;
    assign ifc0.Din_Valid   = ifc1.Din_Valid;
    assign ifc0.Din         = ifc1.Din;

    first_cnn_maxpool #(.IMG_W(W), .IMG_H(H), .DW(DATA_W), .RELU_EN(1)) u_relu (
        .clk (clk),
        .rst (rst),
        .bus (ifc1.slave)
    );

    first_cnn_maxpool #(.IMG_W(W), .IMG_H(H), .DW(DATA_W), .RELU_EN(0)) u_raw (
        .clk (clk),
        .rst (rst),
        .bus (ifc0.slave)
    );

    typedef struct {
        pix_t v1;
        pix_t v0;
        logic done;
        int   cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    int   nout = 0;
    bit   mon_en = 1'b0;
    bit   end_req = 1'b0;
    pix_t img [H][W];
    int   pos = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic pix_t relu(pix_t a);
        return (a < 0) ? pix_t'(0) : a;
    endfunction

    // Reference model: remember every pixel of the frame; on completing a 2x2
    // window, the pooled value is simply the largest of its four pixels.
    task automatic model_accept(pix_t d, bit fs);
        int r, c;
        pix_t win [4];
        pix_t m1, m0;
        if (fs) pos = 0;
        r = pos / W;
        c = pos % W;
        img[r][c] = d;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            win[0] = img[r-1][c-1];
            win[1] = img[r-1][c];
            win[2] = img[r][c-1];
            win[3] = img[r][c];
            m0 = win[0];
            m1 = relu(win[0]);
            for (int i = 1; i < 4; i++) begin
                if (win[i] > m0) m0 = win[i];
                if (relu(win[i]) > m1) m1 = relu(win[i]);
            end
            sb.push_back('{v1: m1, v0: m0, done: (r == H-1) && (c == W-1), cyc: cyc + 1});
        end
        pos = (pos + 1) % (W * H);
    endtask

    task automatic send(pix_t d, bit fs, int gap);
        repeat (gap) begin
            @(posedge clk); #1;
            ifc1.Frame_Start = 1'b0;
            ifc1.Din_Valid   = 1'b0;
            ifc1.Din         = pix_t'($urandom_range(255, 0));
        end
        @(posedge clk); #1;
        ifc1.Frame_Start = fs;
        ifc1.Din_Valid   = 1'b1;
        ifc1.Din         = d;
        model_accept(d, fs);
    endtask

    task automatic go_idle(int n);
        repeat (n) begin
            @(posedge clk); #1;
            ifc1.Frame_Start = 1'b0;
            ifc1.Din_Valid   = 1'b0;
            ifc1.Din         = '0;
        end
    endtask

    // kind: 0 ramp, 1 const -5, 2 const 42, 3 random with extremes
    // (window (0,0) forced to {-128,127,-1,0})
    task automatic frame(int kind, int maxgap, bit fs_first, int npix);
        int r, c;
        pix_t v;
        for (int p = 0; p < npix; p++) begin
            r = p / W;
            c = p % W;
            case (kind)
                0: v = pix_t'((r * W + c) % 128);
                1: v = -8'sd5;
                2: v = 8'sd42;
                default: begin
                    if (r == 0 && c == 0)      v = -8'sd128;
                    else if (r == 0 && c == 1) v = 8'sd127;
                    else if (r == 1 && c == 0) v = -8'sd1;
                    else if (r == 1 && c == 1) v = 8'sd0;
                    else if ($urandom_range(3, 0) == 0)
                        v = ($urandom_range(1, 0) == 1) ? 8'sd127 : -8'sd128;
                    else
                        v = pix_t'($urandom_range(255, 0));
                end
            endcase
            send(v, fs_first && (p == 0), (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst              = 1'b1;
        ifc1.Frame_Start = 1'b0;
        ifc1.Din_Valid   = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        pos = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (ifc1.Dout_Valid === 1'b1 || ifc0.Dout_Valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_out: cyc %0d relu %0d raw %0d, required no output", cyc, ifc1.Dout, ifc0.Dout);
                end else begin
                    e = sb.pop_front();
                    if (ifc1.Dout_Valid === 1'b1 && ifc0.Dout_Valid === 1'b1 &&
                        ifc1.Dout === e.v1 && ifc0.Dout === e.v0 &&
                        ifc1.Frame_Done === e.done && ifc0.Frame_Done === e.done &&
                        cyc == e.cyc) begin
                        passed++;
                    end else begin
                        $display("FAIL out%0d: got relu %0d raw %0d vld %b/%b fd %b/%b cyc %0d, required relu %0d raw %0d fd %b cyc %0d",
                                 nout, ifc1.Dout, ifc0.Dout, ifc1.Dout_Valid, ifc0.Dout_Valid,
                                 ifc1.Frame_Done, ifc0.Frame_Done, cyc, e.v1, e.v0, e.done, e.cyc);
                    end
                end
                nout++;
            end else begin
                checks++;
                if (ifc1.Dout === '0 && ifc0.Dout === '0 &&
                    ifc1.Frame_Done === 1'b0 && ifc0.Frame_Done === 1'b0 &&
                    ifc1.Dout_Valid === 1'b0 && ifc0.Dout_Valid === 1'b0) begin
                    passed++;
                end else begin
                    $display("FAIL idle: cyc %0d Dout %0d/%0d Frame_Done %b/%b, required 0/0 and 0/0",
                             cyc, ifc1.Dout, ifc0.Dout, ifc1.Frame_Done, ifc0.Frame_Done);
                end
                if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                    checks++;
                    e = sb.pop_front();
                    $display("FAIL missing_out: cyc %0d no Dout_Valid, required relu %0d raw %0d at cyc %0d",
                             cyc, e.v1, e.v0, e.cyc);
                end
            end
            if (end_req) begin
                checks++;
                if (sb.size() == 0) passed++;
                else $display("FAIL drain: %0d outputs still expected, required 0", sb.size());
                $display("%0d/%0d checks passed", passed, checks);
                $finish;
            end
        end
    end

    initial begin
        rst              = 1'b1;
        ifc1.Frame_Start = 1'b0;
        ifc1.Din_Valid   = 1'b0;
        ifc1.Din         = '0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        frame(0, 0, 1'b1, W * H);       // ramp
        frame(1, 0, 1'b0, W * H);       // all -5: relu -> 0, raw -> -5
        frame(3, 0, 1'b0, W * H);       // signed extremes
        frame(0, 7, 1'b1, W * H);       // bursty ramp
        go_idle(3);
        frame(0, 0, 1'b1, 300);         // abandoned partial frame
        frame(2, 0, 1'b1, W * H);       // restart with constant 42
        frame(3, 1, 1'b0, 500);         // partial frame cut by reset
        do_reset();
        frame(3, 0, 1'b0, W * H);
        frame(0, 0, 1'b0, W * H);       // back-to-back, no gaps
        frame(3, 2, 1'b0, W * H);
        go_idle(4);
        end_req = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL end: monitor did not reach summary");
        $fatal(1);
    end

endmodule

// File: doc/first_cnn_maxpool.md
Name: first_cnn_maxpool

Overview:
- Downstream neighbour of the 3x3 binary-convolution stage; consumes its signed 8-bit results in raster order, one 32x32 map per frame.
- Applies optional ReLU, then 2x2 stride-2 max pooling, and emits a 16x16 pooled map in raster order with a valid strobe and an end-of-frame pulse.
- Feeds the next CNN layer (flatten/FC stage).

Parameters:
- IMG_W, 32, conv-map width in pixels; must be even, at least 2.
- IMG_H, 32, conv-map height in pixels; must be even, at least 2.
- DW, 8, signed data width of input and output.
- RELU_EN, 1, 1 = clamp negative inputs to 0 before pooling; 0 = pool raw signed values.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- Frame_Start  in  1  pulse; the next accepted pixel is pixel (row 0, col 0).
- Din_Valid  in  1  Din carries a conv pixel this cycle; this is the conv stage's Cal_Valid delayed one cycle.
- Din  in  DW  signed conv result.
- Dout_Valid  out  1  one-cycle strobe marking a pooled pixel.
- Dout  out  DW  signed pooled result.
- Frame_Done  out  1  one-cycle pulse, coincident with the last pooled pixel of a frame.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): Dout=0, Dout_Valid=0, Frame_Done=0, col=0, row=0, h_reg=0. line_mem is not cleared; it is always written on an even row before it is read on the following odd row.
- Counters: col runs 0..IMG_W-1 and advances only on Din_Valid. At IMG_W-1, col wraps to 0 and row increments. row runs 0..IMG_H-1 and wraps to 0 after the last pixel.
- Gaps: Din_Valid low freezes counters, h_reg and line_mem. There is no timeout and no limit on gap length.
- Input conditioning: x = (RELU_EN && Din<0) ? 0 : Din. All comparisons are signed, DW bits wide, with no width growth.
- Per accepted pixel:
  - even row, even col: h_reg <= x.
  - even row, odd col: line_mem[col>>1] <= max(h_reg, x).
  - odd row, even col: h_reg <= max(line_mem[col>>1], x).
  - odd row, odd col: Dout <= max(h_reg, x); Dout_Valid <= 1.
- line_mem: IMG_W/2 entries of DW bits, register or distributed RAM, with combinational read.
- Latency: Dout and Dout_Valid are registered 1 cycle after the accepted (odd row, odd col) input.
- Output idle: when Dout_Valid=0, Dout=0 (drive zero, do not hold the last value).
- Output rate: at most IMG_W/2 outputs per odd row, so (IMG_W/2)*(IMG_H/2) per frame.
- Frame_Done: asserted together with Dout_Valid for input pixel (IMG_H-1, IMG_W-1).
- Frame_Start:
  - Forces col=0 and row=0 for the current cycle.
  - If Din_Valid is high in the same cycle, that pixel is processed as (0,0).
  - Frame_Start mid-frame abandons the partial frame; no Frame_Done is issued for it.
- Reset mid-frame: same effect as an abandoned frame. The first valid pixel after reset is (0,0).
- Ties: max picks either operand; the value is identical, so no requirement applies.
- Extremes: -128 and 127 must compare correctly as signed values (no unsigned compare).

Decomposition:
- Shared package first_cnn_pkg holds:
  - constant CONV_W=32 and CONV_H=32;
  - constant POOL_W=CONV_W/2;
  - constant DATA_W=8;
  - typedef pix_t = signed [DATA_W-1:0];
  - function smax(pix_t a, pix_t b).
- One natural sub-module: first_cnn_pool_linebuf. It owns the IMG_W/2 x DW storage with a single write port and a single combinational read port, indexed by col>>1.
- Counters, ReLU and compare logic stay in first_cnn_maxpool.

Test Plan:
- Ramp frame, RELU_EN=1: Din = (row*32+col) mod 128, continuous valid -> 256 outputs; output k (r=k/16, c=k%16) = ((2r+1)*32+2c+1) mod 128; Frame_Done only with output 255.
- Negative frame: all Din=-5. RELU_EN=1 -> every Dout=0. RELU_EN=0 -> every Dout=-5. Window {-128,127,-1,0} -> 127, proving the signed compare.
- Bursty valid: same ramp frame with Din_Valid low for a random 0-7 cycles between pixels -> identical output sequence; each Dout_Valid exactly 1 cycle after its (odd,odd) input; Dout=0 whenever Dout_Valid=0.
- Frame_Start mid-frame after 300 pixels, then a full frame of constant 42 -> no Frame_Done for the aborted frame; 256 outputs of 42, then Frame_Done.
- rst pulsed for 1 cycle at pixel 500, then a full frame -> all outputs 0 on the cycle after reset; next frame correct with no stale line_mem values; back-to-back frames with no gap keep the correct row/col wrap.
